fpu_unpack: RTL
===============

FPU_UNPACK -- requirements
Module: fpu_unpack

Interface
REQ-001 Parameters SHALL be: GET_A, 4'd0, state code for operand-A accept; GET_B, 4'd1, state code for operand-B accept; UNPACK, 4'd2, state code for field decode; PUT_Z, 4'd3, state code for result offer.
REQ-002 clk  in  1  clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 input_a  in  32  IEEE-754 single operand A.
REQ-005 input_a_stb  in  1  operand A valid.
REQ-006 input_a_ack  out  1  operand A accept.
REQ-007 input_b  in  32  IEEE-754 single operand B.
REQ-008 input_b_stb  in  1  operand B valid.
REQ-009 input_b_ack  out  1  operand B accept.
REQ-010 out_stb  out  1  unpacked result valid.
REQ-011 out_ack  in  1  downstream accepts the result.
REQ-012 a_sign, b_sign  out  1 each  sign bits.
REQ-013 a_exp, b_exp  out  10 each  unbiased exponent, two's complement.
REQ-014 a_man, b_man  out  24 each  mantissa including hidden bit in bit 23.
REQ-015 a_class, b_class  out  3 each  0 zero, 1 normal, 2 denormal, 3 infinity, 4 NaN.
REQ-016 state_out  out  4  current state code.

Function
REQ-017 The FSM SHALL step GET_A -> GET_B -> UNPACK -> PUT_Z -> GET_A; unused codes SHALL go to GET_A.
REQ-018 input_a_ack SHALL equal (state==GET_A && !rst); input_b_ack SHALL equal (state==GET_B && !rst); out_stb SHALL equal (state==PUT_Z).
REQ-019 A transfer SHALL occur on an edge where stb and ack are both high; the word is captured and the FSM advances. Otherwise the state holds, and stb outside the matching state is ignored.
REQ-020 UNPACK SHALL last exactly one cycle and register all decoded fields. out_stb SHALL rise in the second cycle after the edge that accepts B.
REQ-021 In PUT_Z all outputs SHALL stay stable until the edge with out_ack high, which returns the FSM to GET_A. Minimum period is 4 cycles per operand pair.
REQ-022 Decode, with e = bits[30:23] and m = bits[22:0]: sign = bit 31.
- Normal (0<e<255): exp = e-127, man = {1,m}, class 1.
- e=0, m=0: exp = -127 (10'h381), man = 0, class 0.
- e=255, m=0: exp = 128, man = {0,m}, class 3.
- e=255, m!=0: exp = 128, man = {0,m}, class 4.
- Denormal (e=0, m!=0): see REQ-026.

Reset
REQ-023 With rst high at an edge: state = GET_A; all sign/exp/man/class outputs = 0; captured operands = 0; out_stb = 0.
REQ-024 Reset in any state, including PUT_Z with out_stb high, SHALL discard the pending operands. No ack SHALL be asserted while rst is high.

Configuration
REQ-025 Macro FPU_UNPACK_DENORM_EN SHALL select denormal handling.
REQ-026 Defined: a denormal gives exp = -126 (10'h382), man = {0,m}, class 2. Undefined: a denormal is flushed to exp = 10'h381, man = 0, class 0, with the sign preserved.

Verification
REQ-027 a=32'h3F800000, b=32'hC0000000 -> a: sign 0, exp 0, man 24'h800000, class 1; b: sign 1, exp 1, man 24'h800000, class 1; out_stb 2 cycles after B accepted.
REQ-028 a=32'h7F800000, b=32'h7FC00000 -> a: class 3, exp 128, man 0; b: class 4, exp 128, man 24'h400000.
REQ-029 a=32'h00000001, b=32'h80000000:
- With macro: a class 2, exp 10'h382, man 24'h000001.
- Without macro: a class 0, exp 10'h381, man 0.
- Both builds: b sign 1, class 0.
REQ-030 out_ack held low 5 cycles in PUT_Z while input_a_stb is high -> outputs unchanged, input_a_ack stays 0, state_out stays 3.
REQ-031 rst pulsed for one cycle while state_out=2 -> next cycle state_out=0, out_stb=0, all fields 0; a fresh pair then decodes correctly.
REQ-032 All stb inputs and out_ack held high -> state_out cycles 0,1,2,3,0 with one result per 4 cycles.

Source files
------------

// File: rtl/fpu_unpack.sv
// rtl/fpu_unpack.sv - two-operand IEEE-754 single unpacker with stb/ack handshakes.
// Define FPU_UNPACK_DENORM_EN to keep denormals; otherwise they flush to signed zero.
module fpu_unpack (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic        out_stb,
    input  logic        out_ack,
    output logic        a_sign,
    output logic        b_sign,
    output logic [9:0]  a_exp,
    output logic [9:0]  b_exp,
    output logic [23:0] a_man,
    output logic [23:0] b_man,
    output logic [2:0]  a_class,
    output logic [2:0]  b_class,
    output logic [3:0]  state_out
);

    localparam logic [3:0] GET_A  = 4'd0;
    localparam logic [3:0] GET_B  = 4'd1;
    localparam logic [3:0] UNPACK = 4'd2;
    localparam logic [3:0] PUT_Z  = 4'd3;

    localparam logic [2:0] CLS_ZERO   = 3'd0;
    localparam logic [2:0] CLS_NORMAL = 3'd1;
    localparam logic [2:0] CLS_DENORM = 3'd2;
    localparam logic [2:0] CLS_INF    = 3'd3;
    localparam logic [2:0] CLS_NAN    = 3'd4;

    localparam logic [9:0] EXP_ZERO   = 10'h381;
    localparam logic [9:0] EXP_DENORM = 10'h382;
    localparam logic [9:0] EXP_SPEC   = 10'd128;
    localparam logic [9:0] EXP_BIAS   = 10'd127;

    // Packed field word: {sign, exp[9:0], man[23:0], class[2:0]}
    function automatic logic [37:0] decode(input logic [31:0] w);
        logic [7:0]  e;
        logic [22:0] m;
        logic [9:0]  ex;
        logic [23:0] mn;
        logic [2:0]  cl;
        e = w[30:23];
        m = w[22:0];
        if (e == 8'hFF) begin
            ex = EXP_SPEC;
            mn = {1'b0, m};
            cl = (m == 23'd0) ? CLS_INF : CLS_NAN;
        end else if (e == 8'h00) begin
            if (m == 23'd0) begin
                ex = EXP_ZERO;
                mn = 24'd0;
                cl = CLS_ZERO;
            end else begin
`ifdef FPU_UNPACK_DENORM_EN
                ex = EXP_DENORM;
                mn = {1'b0, m};
                cl = CLS_DENORM;
`else
                ex = EXP_ZERO;
                mn = 24'd0;
                cl = CLS_ZERO;
`endif
            end
        end else begin
            ex = {2'b00, e} - EXP_BIAS;
            mn = {1'b1, m};
            cl = CLS_NORMAL;
        end
        return {w[31], ex, mn, cl};
    endfunction

    logic [3:0]  state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [37:0] a_fields_q, a_fields_d;
    logic [37:0] b_fields_q, b_fields_d;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        a_fields_d = a_fields_q;
        b_fields_d = b_fields_q;
        case (state_q)
            GET_A: begin
                if (input_a_stb) begin
                    a_d     = input_a;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (input_b_stb) begin
                    b_d     = input_b;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                a_fields_d = decode(a_q);
                b_fields_d = decode(b_q);
                state_d    = PUT_Z;
            end
            PUT_Z: begin
                if (out_ack) begin
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= GET_A;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            a_fields_q <= 38'd0;
            b_fields_q <= 38'd0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            a_fields_q <= a_fields_d;
            b_fields_q <= b_fields_d;
        end
    end

    // Acks are gated by rst so nothing is accepted on a reset edge
    assign input_a_ack = (state_q == GET_A) && !rst;
    assign input_b_ack = (state_q == GET_B) && !rst;
    assign out_stb     = (state_q == PUT_Z);
    assign state_out   = state_q;

    assign a_sign  = a_fields_q[37];
    assign a_exp   = a_fields_q[36:27];
    assign a_man   = a_fields_q[26:3];
    assign a_class = a_fields_q[2:0];
    assign b_sign  = b_fields_q[37];
    assign b_exp   = b_fields_q[36:27];
    assign b_man   = b_fields_q[26:3];
    assign b_class = b_fields_q[2:0];

endmodule
